// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout, NOP encoding, halt opcode
// and the fetch halt-FSM state type, used by fetch, decode and execute.
package cpu_pkg;
  localparam int unsigned ADDR_W_DEFAULT = 16;
  localparam logic [15:0] NOP_INSTR      = 16'h0000;
  localparam logic [3:0]  HALT_OPC       = 4'hF;

  localparam int unsigned OPC_MSB  = 15;
  localparam int unsigned OPC_LSB  = 12;
  localparam int unsigned IMMF_BIT = 11;
  localparam int unsigned RD_MSB   = 10;
  localparam int unsigned RD_LSB   = 8;
  localparam int unsigned RS1_MSB  = 7;
  localparam int unsigned RS1_LSB  = 5;
  localparam int unsigned RS2_MSB  = 4;
  localparam int unsigned RS2_LSB  = 2;
  localparam int unsigned IMM_MSB  = 4;
  localparam int unsigned IMM_LSB  = 0;

  typedef enum logic {
    FETCH_RUN,
    FETCH_HALT
  } fetch_state_e;

  function automatic logic [3:0] opcode_of(input logic [15:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {instruction, word address} pairs with flush.
// Head entry is presented combinationally; flush empties it in one cycle.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned QDEPTH = 4,
  localparam int unsigned PTR_W = $clog2(QDEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [15:0]       push_instr,
  input  logic [ADDR_W-1:0] push_addr,
  output logic [15:0]       head_instr,
  output logic [ADDR_W-1:0] head_addr,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
);
  logic [15:0]       instr_mem [QDEPTH];
  logic [ADDR_W-1:0] addr_mem  [QDEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_pop;

  assign do_pop     = pop && !empty;
  assign empty      = (count == '0);
  assign full       = (count == CNT_W'(QDEPTH));
  assign head_instr = instr_mem[rd_ptr];
  assign head_addr  = addr_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        instr_mem[wr_ptr] <= push_instr;
        addr_mem[wr_ptr]  <= push_addr;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The fetch credit scheme must never let a response land on a full queue.
  always_ff @(posedge clk) begin
    if (!reset && !flush && push) assert (!full);
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited issue to a 1-cycle imem,
// response queue toward decode, branch redirect/flush and halt FSM.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W      = ADDR_W_DEFAULT,
  parameter int unsigned       QDEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [3:0]        HALT_OPCODE = HALT_OPC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              is_branch_taken,
  input  logic [15:0]       branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted
);
  localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_addr;
  logic              inflight;
  logic              squash;
  logic [CNT_W-1:0]  q_count;
  logic              q_empty;
  logic              q_full;
  logic [15:0]       head_instr;
  logic [ADDR_W-1:0] head_addr;
  logic              ret_valid;
  logic              push_halt;
  logic              pop;

  assign ret_valid = inflight && !squash;
  assign push_halt = ret_valid && (opcode_of(imem_rdata) == HALT_OPCODE);

  // Outstanding requests count against queue space so every response has a slot.
  assign imem_req = !reset && (state == FETCH_RUN) && !is_branch_taken &&
                    ((q_count + CNT_W'(inflight)) < CNT_W'(QDEPTH));
  assign imem_addr = pc;

  assign instr_valid = !q_empty && !is_branch_taken;
  assign instr       = instr_valid ? head_instr : NOP_INSTR;
  assign pc_out      = instr_valid ? head_addr : '0;
  assign pop         = instr_valid && !stall;
  assign halted      = (state == FETCH_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH_RUN;
      pc       <= RESET_PC;
      req_addr <= '0;
      inflight <= 1'b0;
      squash   <= 1'b0;
    end else if (is_branch_taken) begin
      state    <= FETCH_RUN;
      pc       <= branch_target[ADDR_W-1:0];
      inflight <= 1'b0;
      squash   <= inflight;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        pc       <= pc + 1'b1;
        req_addr <= pc;
      end
      // A request issued alongside the halt word's return fetches past the
      // halt; its response is discarded so only words up to the halt drain.
      squash <= push_halt && imem_req;
      if (push_halt) state <= FETCH_HALT;
    end
  end

  fetch_queue #(
    .ADDR_W(ADDR_W),
    .QDEPTH(QDEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (ret_valid),
    .pop       (pop),
    .flush     (is_branch_taken),
    .push_instr(imem_rdata),
    .push_addr (req_addr),
    .head_instr(head_instr),
    .head_addr (head_addr),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

  logic unused_full;
  assign unused_full = q_full;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, redirect, halt, PC wrap,
// back-to-back redirects and reset with a full queue.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        is_branch_taken;
  logic [15:0] branch_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = '0;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] pc_out;
  logic        halted;
  logic        halt_mode;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  fetch_unit #(
    .ADDR_W     (16),
    .QDEPTH     (4),
    .RESET_PC   (16'h0000),
    .HALT_OPCODE(4'hF)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .is_branch_taken(is_branch_taken),
    .branch_target  (branch_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .pc_out         (pc_out),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] word_at(input logic [15:0] a, input logic hm);
    if (hm && a == 16'h0005) return 16'hF000;
    return 16'h1000 + a;
  endfunction

  always @(posedge clk) if (imem_req) imem_rdata <= word_at(imem_addr, halt_mode);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; is_branch_taken = 1'b0;
    branch_target = '0; halt_mode = 1'b0;
    repeat (2) tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'h0);
    chk("rst_pc_out", 32'(pc_out), 32'h0);
    chk("rst_halted", 32'(halted), 32'd0);

    // Streaming: first request, then first valid two cycles later
    reset = 1'b0; #1;
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", 32'(imem_addr), 32'h0);
    tick();
    chk("lat_valid0", 32'(instr_valid), 32'd0);
    chk("second_addr", 32'(imem_addr), 32'h1);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("stream_instr", 32'(instr), 32'h1000 + 32'(k));
      chk("stream_pc", 32'(pc_out), 32'(k));
      chk("stream_valid", 32'(instr_valid), 32'd1);
      if (k < 2) tick();
    end

    // Stall holding 1002: requests stop once credit is used up
    stall = 1'b1; #1;
    for (int k = 0; k < 6; k++) begin
      chk("stall_instr", 32'(instr), 32'h1002);
      chk("stall_pc", 32'(pc_out), 32'h2);
      chk("stall_req", 32'(imem_req), (k < 2) ? 32'd1 : 32'd0);
      tick();
    end
    stall = 1'b0; #1;
    for (int k = 0; k < 5; k++) begin
      chk("release_instr", 32'(instr), 32'h1002 + 32'(k));
      chk("release_pc", 32'(pc_out), 32'h2 + 32'(k));
      tick();
    end

    // Redirect to 0x40 with a response in flight
    is_branch_taken = 1'b1; branch_target = 16'h0040; #1;
    chk("br_valid", 32'(instr_valid), 32'd0);
    chk("br_instr", 32'(instr), 32'h0);
    chk("br_req", 32'(imem_req), 32'd0);
    tick();
    is_branch_taken = 1'b0; #1;
    chk("br_next_valid", 32'(instr_valid), 32'd0);
    chk("br_next_addr", 32'(imem_addr), 32'h40);
    chk("br_next_req", 32'(imem_req), 32'd1);
    tick(); tick();
    chk("br_tgt_instr", 32'(instr), 32'h1040);
    chk("br_tgt_pc", 32'(pc_out), 32'h40);

    // Halt word at address 5
    halt_mode = 1'b1;
    is_branch_taken = 1'b1; branch_target = 16'h0000;
    tick();
    is_branch_taken = 1'b0;
    tick(); tick();
    for (int k = 0; k < 6; k++) begin
      chk("halt_drain_instr", 32'(instr), (k < 5) ? 32'h1000 + 32'(k) : 32'hF000);
      chk("halt_drain_pc", 32'(pc_out), 32'(k));
      if (k < 5) tick();
    end
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_no_req", 32'(imem_req), 32'd0);
    tick();
    chk("halt_empty", 32'(instr_valid), 32'd0);
    chk("halt_still_no_req", 32'(imem_req), 32'd0);
    tick();
    chk("halt_hold", 32'(halted), 32'd1);

    is_branch_taken = 1'b1; branch_target = 16'h0010;
    tick();
    is_branch_taken = 1'b0; #1;
    chk("resume_halted", 32'(halted), 32'd0);
    chk("resume_req", 32'(imem_req), 32'd1);
    chk("resume_addr", 32'(imem_addr), 32'h10);
    tick(); tick();
    chk("resume_instr", 32'(instr), 32'h1010);
    chk("resume_pc", 32'(pc_out), 32'h10);

    // PC wrap at 0xFFFF
    is_branch_taken = 1'b1; branch_target = 16'hFFFF;
    tick();
    is_branch_taken = 1'b0; #1;
    chk("wrap_addr_ffff", 32'(imem_addr), 32'hFFFF);
    tick();
    chk("wrap_addr_0", 32'(imem_addr), 32'h0);
    chk("wrap_req", 32'(imem_req), 32'd1);
    tick();
    chk("wrap_instr_ffff", 32'(instr), 32'h0FFF);
    chk("wrap_pc_ffff", 32'(pc_out), 32'hFFFF);
    tick();
    chk("wrap_instr_0", 32'(instr), 32'h1000);
    chk("wrap_pc_0", 32'(pc_out), 32'h0);

    // Back-to-back redirects: the second target wins
    is_branch_taken = 1'b1; branch_target = 16'h0020;
    tick();
    branch_target = 16'h0030; #1;
    chk("b2b_valid", 32'(instr_valid), 32'd0);
    tick();
    is_branch_taken = 1'b0; #1;
    chk("b2b_addr", 32'(imem_addr), 32'h30);
    tick(); tick();
    chk("b2b_instr", 32'(instr), 32'h1030);
    chk("b2b_pc", 32'(pc_out), 32'h30);

    // Fill queue under stall (halting at 5), then reset
    is_branch_taken = 1'b1; branch_target = 16'h0002; stall = 1'b1;
    tick();
    is_branch_taken = 1'b0;
    repeat (5) tick();
    chk("full_halted", 32'(halted), 32'd1);
    chk("full_instr", 32'(instr), 32'h1002);
    chk("full_pc", 32'(pc_out), 32'h2);
    chk("full_no_req", 32'(imem_req), 32'd0);
    reset = 1'b1;
    tick();
    chk("mid_rst_instr", 32'(instr), 32'h0);
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    chk("mid_rst_halted", 32'(halted), 32'd0);
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_pc_out", 32'(pc_out), 32'h0);
    reset = 1'b0; stall = 1'b0; #1;
    chk("post_rst_req", 32'(imem_req), 32'd1);
    chk("post_rst_addr", 32'(imem_addr), 32'h0);
    tick();
    chk("post_rst_lat", 32'(instr_valid), 32'd0);
    tick();
    chk("post_rst_instr", 32'(instr), 32'h1000);
    chk("post_rst_pc", 32'(pc_out), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
